// File: rtl/display_arbiter.sv
// Display owner: shows the base view, or a captured A/B message for a fixed number of ms ticks.
// The message can optionally blink. Requester B has priority over A, and every output is registered.
module display_arbiter #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned BLINK_MS = 250,
  parameter int unsigned DUR_W    = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [39:0]      base_digits,
  input  logic [7:0]       base_dots,
  input  logic             req_a,
  input  logic [39:0]      a_digits,
  input  logic [7:0]       a_dots,
  input  logic [DUR_W-1:0] a_dur,
  input  logic             a_blink,
  output logic             ack_a,
  output logic             done_a,
  input  logic             req_b,
  input  logic [39:0]      b_digits,
  input  logic [7:0]       b_dots,
  input  logic [DUR_W-1:0] b_dur,
  input  logic             b_blink,
  output logic             ack_b,
  output logic             done_b,
  input  logic             cancel,
  output logic [39:0]      disp_digits,
  output logic [7:0]       disp_dots,
  output logic [1:0]       disp_src,
  output logic             busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [1:0] SRC_BASE = 2'd0;
  localparam logic [1:0] SRC_A    = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;

  typedef enum logic {IDLE, SHOW} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0] tick_q, tick_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             blink_q, blink_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             blank_q, blank_d;
  logic [39:0]      msg_dig_q, msg_dig_d;
  logic [7:0]       msg_dots_q, msg_dots_d;
  logic [39:0]      dig_q, dig_d;
  logic [7:0]       dots_q, dots_d;
  logic [1:0]       src_q, src_d;
  logic             busy_q, busy_d;
  logic             ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic             done_a_q, done_a_d, done_b_q, done_b_d;

  logic tick_w, timeout_w, exit_w, grant_a_w, grant_b_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_q     <= '0;
      dur_q      <= '0;
      blink_q    <= 1'b0;
      bcnt_q     <= '0;
      blank_q    <= 1'b0;
      msg_dig_q  <= '1;
      msg_dots_q <= '0;
      dig_q      <= '1;
      dots_q     <= '0;
      src_q      <= SRC_BASE;
      busy_q     <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
      blink_q    <= blink_d;
      bcnt_q     <= bcnt_d;
      blank_q    <= blank_d;
      msg_dig_q  <= msg_dig_d;
      msg_dots_q <= msg_dots_d;
      dig_q      <= dig_d;
      dots_q     <= dots_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      done_a_q   <= done_a_d;
      done_b_q   <= done_b_d;
    end
  end

  // Timeout fires on the edge that completes tick number dur.
  always_comb begin
    tick_w    = (presc_q == PW'(TICK_DIV - 1));
    timeout_w = tick_w && ((tick_q + 1'b1) == dur_q);
    exit_w    = (state_q == SHOW) && (cancel || timeout_w);
    grant_b_w = (state_q == IDLE) && req_b;
    grant_a_w = (state_q == IDLE) && req_a && !req_b;
    state_d   = state_q;
    if (grant_a_w || grant_b_w) state_d = SHOW;
    else if (exit_w)            state_d = IDLE;
  end

  always_comb begin
    presc_d    = presc_q;
    tick_d     = tick_q;
    dur_d      = dur_q;
    blink_d    = blink_q;
    bcnt_d     = bcnt_q;
    blank_d    = blank_q;
    msg_dig_d  = msg_dig_q;
    msg_dots_d = msg_dots_q;
    dig_d      = dig_q;
    dots_d     = dots_q;
    src_d      = src_q;
    busy_d     = busy_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    done_a_d   = 1'b0;
    done_b_d   = 1'b0;
    if (state_q == IDLE) begin
      dig_d  = base_digits;
      dots_d = base_dots;
      src_d  = SRC_BASE;
      busy_d = 1'b0;
      if (grant_a_w || grant_b_w) begin
        msg_dig_d  = grant_b_w ? b_digits : a_digits;
        msg_dots_d = grant_b_w ? b_dots : a_dots;
        dur_d      = grant_b_w ? b_dur : a_dur;
        if (dur_d == '0) dur_d = DUR_W'(1);
        blink_d    = grant_b_w ? b_blink : a_blink;
        presc_d    = '0;
        tick_d     = '0;
        bcnt_d     = '0;
        blank_d    = 1'b0;
        dig_d      = msg_dig_d;
        dots_d     = msg_dots_d;
        src_d      = grant_b_w ? SRC_B : SRC_A;
        busy_d     = 1'b1;
        ack_a_d    = grant_a_w;
        ack_b_d    = grant_b_w;
      end
    end else if (exit_w) begin
      dig_d    = base_digits;
      dots_d   = base_dots;
      src_d    = SRC_BASE;
      busy_d   = 1'b0;
      done_a_d = (src_q == SRC_A);
      done_b_d = (src_q == SRC_B);
    end else begin
      presc_d = tick_w ? '0 : presc_q + 1'b1;
      if (tick_w) begin
        tick_d = tick_q + 1'b1;
        if (blink_q) begin
          if (bcnt_q == BW'(BLINK_MS - 1)) begin
            bcnt_d  = '0;
            blank_d = !blank_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      dig_d  = blank_d ? '1 : msg_dig_q;
      dots_d = blank_d ? '0 : msg_dots_q;
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign done_a      = done_a_q;
  assign done_b      = done_b_q;
  assign disp_digits = dig_q;
  assign disp_dots   = dots_q;
  assign disp_src    = src_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: stimulus queues expected ack/done events and view snapshots.
// A negedge monitor pops and compares them.
module tb_display_arbiter;

  localparam int unsigned TD = 4;
  localparam int unsigned BM = 2;
  localparam int unsigned DW = 12;

  localparam logic [39:0] BASE  = {5'h1F, 5'h1F, 5'h1F, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [39:0] BASE2 = {8{5'h07}};
  localparam logic [39:0] MA    = {8{5'h0A}};
  localparam logic [39:0] MB    = {8{5'h0B}};
  localparam logic [39:0] ALL1  = {40{1'b1}};
  localparam logic [3:0]  EV_ACK_A  = 4'b0001;
  localparam logic [3:0]  EV_ACK_B  = 4'b0010;
  localparam logic [3:0]  EV_DONE_A = 4'b0100;
  localparam logic [3:0]  EV_DONE_B = 4'b1000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [39:0]   base_digits;
  logic [7:0]    base_dots;
  logic          req_a, a_blink, ack_a, done_a;
  logic [39:0]   a_digits;
  logic [7:0]    a_dots;
  logic [DW-1:0] a_dur;
  logic          req_b, b_blink, ack_b, done_b;
  logic [39:0]   b_digits;
  logic [7:0]    b_dots;
  logic [DW-1:0] b_dur;
  logic          cancel;
  logic [39:0]   disp_digits;
  logic [7:0]    disp_dots;
  logic [1:0]    disp_src;
  logic          busy;

  always #5 clk = ~clk;

  display_arbiter #(.TICK_DIV(TD), .BLINK_MS(BM), .DUR_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .base_digits(base_digits), .base_dots(base_dots),
    .req_a(req_a), .a_digits(a_digits), .a_dots(a_dots), .a_dur(a_dur), .a_blink(a_blink),
    .ack_a(ack_a), .done_a(done_a),
    .req_b(req_b), .b_digits(b_digits), .b_dots(b_dots), .b_dur(b_dur), .b_blink(b_blink),
    .ack_b(ack_b), .done_b(done_b),
    .cancel(cancel),
    .disp_digits(disp_digits), .disp_dots(disp_dots), .disp_src(disp_src), .busy(busy)
  );

  typedef struct {
    logic [3:0]  kind;
    int          cyc;
    logic [39:0] dig;
    logic [7:0]  dots;
    logic [1:0]  src;
    logic        busy;
  } exp_t;

  exp_t  evq[$];
  exp_t  snq[$];
  string snn[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  logic  probe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp_view(input string nm, input exp_t e);
    logic [50:0] act, req;
    act = {disp_digits, disp_dots, disp_src, busy};
    req = {e.dig, e.dots, e.src, e.busy};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got digits=%h dots=%h src=%0d busy=%0b expected digits=%h dots=%h src=%0d busy=%0b",
               nm, cyc, disp_digits, disp_dots, disp_src, busy, e.dig, e.dots, e.src, e.busy);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] k;
    exp_t e;
    string nm;
    k = {done_b, done_a, ack_b, ack_a};
    if (k != 4'b0) begin
      checks++;
      if (evq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got=%b expected none", cyc, k);
      end else begin
        e = evq.pop_front();
        if (k !== e.kind || cyc != e.cyc) begin
          failures++;
          $display("FAIL event got kind=%b cyc=%0d expected kind=%b cyc=%0d", k, cyc, e.kind, e.cyc);
        end
        cmp_view("event_view", e);
      end
    end
    if (probe) begin
      checks++;
      if (snq.size() == 0) begin
        failures++;
        $display("FAIL snapshot_queue cyc=%0d got empty expected entry", cyc);
      end else begin
        checks--;
        e  = snq.pop_front();
        nm = snn.pop_front();
        cmp_view(nm, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    probe = 1'b0;
    if (ack_a) req_a = 1'b0;
    if (ack_b) req_b = 1'b0;
  endtask

  task automatic goto_c(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_ev(input logic [3:0] kind, input int c, input logic [39:0] dig,
                         input logic [7:0] dots, input logic [1:0] src, input logic bsy);
    exp_t e;
    e.kind = kind; e.cyc = c; e.dig = dig; e.dots = dots; e.src = src; e.busy = bsy;
    evq.push_back(e);
  endtask

  task automatic snap(input string nm, input logic [39:0] dig, input logic [7:0] dots,
                      input logic [1:0] src, input logic bsy);
    exp_t e;
    e.kind = 4'b0; e.cyc = cyc; e.dig = dig; e.dots = dots; e.src = src; e.busy = bsy;
    snq.push_back(e);
    snn.push_back(nm);
    probe = 1'b1;
  endtask

  initial begin
    int k;
    reset_n = 1'b0; cancel = 1'b0;
    base_digits = BASE; base_dots = 8'h05;
    req_a = 1'b0; a_digits = MA; a_dots = 8'hF0; a_dur = '0; a_blink = 1'b0;
    req_b = 1'b0; b_digits = MB; b_dots = 8'h0F; b_dur = '0; b_blink = 1'b0;
    tick(); tick();
    snap("reset_view", ALL1, 8'h00, 2'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    snap("base_after_reset", BASE, 8'h05, 2'd0, 1'b0);
    tick();

    // Single A message, 3 ticks, no blink
    k = cyc; a_dur = 12'd3; a_blink = 1'b0; req_a = 1'b1;
    push_ev(EV_ACK_A, k + 1, MA, 8'hF0, 2'd1, 1'b1);
    push_ev(EV_DONE_A, k + 13, BASE, 8'h05, 2'd0, 1'b0);
    goto_c(k + 12); snap("a_last_cycle", MA, 8'hF0, 2'd1, 1'b1);
    goto_c(k + 14); snap("base_restored", BASE, 8'h05, 2'd0, 1'b0);
    tick();

    // Simultaneous requests: B wins, A follows one IDLE cycle after done_b
    k = cyc; a_dur = 12'd2; b_dur = 12'd1; b_blink = 1'b0; req_a = 1'b1; req_b = 1'b1;
    push_ev(EV_ACK_B, k + 1, MB, 8'h0F, 2'd2, 1'b1);
    push_ev(EV_DONE_B, k + 5, BASE, 8'h05, 2'd0, 1'b0);
    push_ev(EV_ACK_A, k + 6, MA, 8'hF0, 2'd1, 1'b1);
    push_ev(EV_DONE_A, k + 14, BASE, 8'h05, 2'd0, 1'b0);
    goto_c(k + 3); snap("b_shown", MB, 8'h0F, 2'd2, 1'b1);
    goto_c(k + 15); tick();

    // Blinking A: 8 visible, 8 blank, 8 visible
    k = cyc; a_dur = 12'd6; a_blink = 1'b1; req_a = 1'b1;
    push_ev(EV_ACK_A, k + 1, MA, 8'hF0, 2'd1, 1'b1);
    push_ev(EV_DONE_A, k + 25, BASE, 8'h05, 2'd0, 1'b0);
    goto_c(k + 8);  snap("vis1_end", MA, 8'hF0, 2'd1, 1'b1);
    goto_c(k + 9);  snap("blank_start", ALL1, 8'h00, 2'd1, 1'b1);
    goto_c(k + 16); snap("blank_end", ALL1, 8'h00, 2'd1, 1'b1);
    goto_c(k + 17); snap("vis2_start", MA, 8'hF0, 2'd1, 1'b1);
    goto_c(k + 24); snap("vis2_end", MA, 8'hF0, 2'd1, 1'b1);
    goto_c(k + 26); snap("blink_exit_base", BASE, 8'h05, 2'd0, 1'b0);
    a_blink = 1'b0;
    tick();

    // Cancel of B, then cancel in IDLE
    k = cyc; b_dur = 12'd5; req_b = 1'b1;
    push_ev(EV_ACK_B, k + 1, MB, 8'h0F, 2'd2, 1'b1);
    push_ev(EV_DONE_B, k + 7, BASE, 8'h05, 2'd0, 1'b0);
    goto_c(k + 6); cancel = 1'b1;
    tick(); cancel = 1'b0;
    snap("cancel_base", BASE, 8'h05, 2'd0, 1'b0);
    tick();
    cancel = 1'b1;
    tick(); tick();
    snap("cancel_idle", BASE, 8'h05, 2'd0, 1'b0);
    tick(); cancel = 1'b0;
    tick();

    // Zero duration acts as one tick; base change frozen out during SHOW
    k = cyc; a_dur = 12'd0; req_a = 1'b1;
    push_ev(EV_ACK_A, k + 1, MA, 8'hF0, 2'd1, 1'b1);
    push_ev(EV_DONE_A, k + 5, BASE2, 8'h05, 2'd0, 1'b0);
    goto_c(k + 2); base_digits = BASE2;
    tick(); snap("frozen", MA, 8'hF0, 2'd1, 1'b1);
    goto_c(k + 6); snap("base2_view", BASE2, 8'h05, 2'd0, 1'b0);
    tick();

    // Reset mid-SHOW: blank outputs, no done pulse afterwards
    k = cyc; a_dur = 12'd10; base_digits = BASE; req_a = 1'b1;
    push_ev(EV_ACK_A, k + 1, MA, 8'hF0, 2'd1, 1'b1);
    goto_c(k + 3); reset_n = 1'b0;
    snap("reset_mid_show", ALL1, 8'h00, 2'd0, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); snap("base_after_reset2", BASE, 8'h05, 2'd0, 1'b0);
    repeat (50) tick();

    checks++;
    if (evq.size() != 0 || snq.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got events=%0d snaps=%0d expected 0", evq.size(), snq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
